// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared types and constants for the seg7 digit scanner
package seg7_pkg;

  typedef struct packed {
    logic       en;
    logic [3:0] nibble;
  } hex_code_t;

  localparam hex_code_t HEX_BLANK = 5'b0_0000;

  typedef enum logic {
    BLANK,
    SHOW
  } state_t;

endpackage

// File: rtl/seg7_lz_mask.sv
// rtl/seg7_lz_mask.sv - leading-zero mask over the active digit value
// Digit 0 is never masked so an all-zero value still shows a single "0".
module seg7_lz_mask #(
  parameter int NUM_DIGITS = 8
) (
  input  logic [4*NUM_DIGITS-1:0] i_act_val,
  input  logic                    i_blank_lz,
  output logic [NUM_DIGITS-1:0]   o_lz
);

  // w_zero_run[i] is high when blanking is on and nibbles i..top are all zero
  logic [NUM_DIGITS:1] w_zero_run;

  assign w_zero_run[NUM_DIGITS] = i_blank_lz;

  for (genvar i = 1; i < NUM_DIGITS; i++) begin : g_run
    assign w_zero_run[i] = w_zero_run[i+1] & (i_act_val[4*i +: 4] == 4'h0);
  end

  assign o_lz = {w_zero_run[NUM_DIGITS-1:1], 1'b0};

endmodule

// File: rtl/seg7_scanner.sv
// rtl/seg7_scanner.sv - multiplexed 7-segment scanner with blank dead time and tear-free loads
// Shadow registers take a handshake load; the active set only changes on the frame_done cycle.
module seg7_scanner
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS   = 8,
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [4*NUM_DIGITS-1:0]       value,
  input  logic [NUM_DIGITS-1:0]         digit_en,
  input  logic                          blank_lz,
  input  logic                          load_valid,
  output logic                          load_ready,
  output logic [4:0]                    hex,
  output logic [NUM_DIGITS-1:0]         anodes,
  output logic [$clog2(NUM_DIGITS)-1:0] digit_idx,
  output logic                          frame_done
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] CNT_SHOW = CW'(BLANK_CYCLES);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

  logic [CW-1:0]           r_cnt;
  logic [CW-1:0]           w_cnt_nx;
  logic [IW-1:0]           r_idx;
  logic [IW-1:0]           w_idx_nx;
  logic                    w_wrap;
  state_t                  r_state;
  state_t                  w_state_nx;

  logic [NUM_DIGITS-1:0]   r_anodes;
  logic [NUM_DIGITS-1:0]   w_anodes_nx;
  hex_code_t               r_hex;
  hex_code_t               w_hex_nx;
  hex_code_t               w_sel;
  logic                    r_frame_done;
  logic                    w_frame_done_nx;

  logic                    r_pending;
  logic [4*NUM_DIGITS-1:0] r_sh_val;
  logic [NUM_DIGITS-1:0]   r_sh_en;
  logic                    r_sh_blz;
  logic [4*NUM_DIGITS-1:0] r_act_val;
  logic [NUM_DIGITS-1:0]   r_act_en;
  logic                    r_act_blz;
  logic [NUM_DIGITS-1:0]   w_lz;
  logic                    w_load;
  logic                    w_apply;

  seg7_lz_mask #(
    .NUM_DIGITS(NUM_DIGITS)
  ) u_lz_mask (
    .i_act_val (r_act_val),
    .i_blank_lz(r_act_blz),
    .o_lz      (w_lz)
  );

  always_comb begin
    w_wrap   = (r_cnt == CNT_LAST);
    w_cnt_nx = w_wrap ? '0 : r_cnt + CW'(1);
    w_idx_nx = r_idx;
    if (w_wrap) begin
      w_idx_nx = (r_idx == IDX_LAST) ? '0 : r_idx + IW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= BLANK;
    end else begin
      r_state <= w_state_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      BLANK:   if (w_cnt_nx == CNT_SHOW) w_state_nx = SHOW;
      SHOW:    if (w_wrap) w_state_nx = BLANK;
      default: w_state_nx = BLANK;
    endcase
  end

  // Outputs are computed from next-cycle state so the registered pins line up with the slot counter
  always_comb begin
    w_sel = HEX_BLANK;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (w_idx_nx == IW'(i)) begin
        w_sel.en     = r_act_en[i] & ~w_lz[i];
        w_sel.nibble = r_act_val[4*i +: 4];
      end
    end
    w_anodes_nx     = '1;
    w_hex_nx        = HEX_BLANK;
    w_frame_done_nx = (w_cnt_nx == CNT_LAST) && (w_idx_nx == IDX_LAST);
    if (w_state_nx == SHOW) begin
      w_anodes_nx = ~(NUM_DIGITS'(1) << w_idx_nx);
      w_hex_nx    = w_sel;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt        <= '0;
      r_idx        <= '0;
      r_anodes     <= '1;
      r_hex        <= HEX_BLANK;
      r_frame_done <= 1'b0;
    end else begin
      r_cnt        <= w_cnt_nx;
      r_idx        <= w_idx_nx;
      r_anodes     <= w_anodes_nx;
      r_hex        <= w_hex_nx;
      r_frame_done <= w_frame_done_nx;
    end
  end

  // A load and an apply never coincide: a load needs pending low, an apply needs it high
  assign w_load  = load_valid & ~r_pending;
  assign w_apply = r_frame_done & r_pending;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pending <= 1'b0;
      r_sh_val  <= '0;
      r_sh_en   <= '0;
      r_sh_blz  <= 1'b0;
      r_act_val <= '0;
      r_act_en  <= '0;
      r_act_blz <= 1'b0;
    end else if (w_load) begin
      r_pending <= 1'b1;
      r_sh_val  <= value;
      r_sh_en   <= digit_en;
      r_sh_blz  <= blank_lz;
    end else if (w_apply) begin
      r_pending <= 1'b0;
      r_act_val <= r_sh_val;
      r_act_en  <= r_sh_en;
      r_act_blz <= r_sh_blz;
    end
  end

  assign load_ready = ~r_pending;
  assign hex        = r_hex;
  assign anodes     = r_anodes;
  assign digit_idx  = r_idx;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_seg7_scanner.sv
// tb/tb_seg7_scanner.sv - self-checking bench for seg7_scanner (4 digits, 8-cycle slots, 2 blank cycles)
module tb_seg7_scanner;

  localparam int ND    = 4;
  localparam int RD    = 8;
  localparam int BC    = 2;
  localparam int FRAME = ND * RD;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] value;
  logic [3:0]  digit_en;
  logic        blank_lz;
  logic        load_valid;
  logic        load_ready;
  logic [4:0]  hex;
  logic [3:0]  anodes;
  logic [1:0]  digit_idx;
  logic        frame_done;

  seg7_scanner #(
    .NUM_DIGITS  (ND),
    .REFRESH_DIV (RD),
    .BLANK_CYCLES(BC)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .value     (value),
    .digit_en  (digit_en),
    .blank_lz  (blank_lz),
    .load_valid(load_valid),
    .load_ready(load_ready),
    .hex       (hex),
    .anodes    (anodes),
    .digit_idx (digit_idx),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // codes_t[s] is the expected hex code for slot s
  typedef logic [3:0][4:0] codes_t;

  typedef struct {
    logic [15:0] val;
    logic [3:0]  en;
    logic        blz;
    codes_t      codes;
  } vec_t;

  typedef struct {
    int     start;
    codes_t codes;
  } sched_t;

  sched_t sb[$];
  codes_t cur_codes;
  codes_t pend_codes;
  int     pos;
  int     n_vec;
  int     n_err;
  int     last_start;
  bit     m_pending;
  bit     taken;
  vec_t   vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s pos=%0d got %h expected %h", name, pos, act, exp);
    end
  endtask

  task automatic check_cycle();
    int        cnt;
    int        slot;
    logic [3:0] ea;
    logic [4:0] eh;
    sched_t    e;
    while (sb.size() > 0 && pos >= sb[0].start) begin
      e = sb.pop_front();
      cur_codes = e.codes;
    end
    cnt  = pos % RD;
    slot = (pos / RD) % ND;
    ea   = 4'hF;
    eh   = 5'h00;
    if (cnt >= BC) begin
      ea = ~(4'b0001 << slot);
      eh = cur_codes[slot];
    end
    check("anodes", 32'(anodes), 32'(ea));
    check("hex", 32'(hex), 32'(eh));
    check("digit_idx", 32'(digit_idx), 32'(slot[1:0]));
    check("frame_done", 32'(frame_done), 32'(pos % FRAME == FRAME - 1));
    check("load_ready", 32'(load_ready), 32'(!m_pending));
  endtask

  task automatic tick();
    bit     acc;
    bit     fd;
    sched_t e;
    acc = load_valid && !m_pending;
    fd  = (pos % FRAME == FRAME - 1);
    if (acc) begin
      e.start = ((pos + 1) / FRAME + 1) * FRAME;
      e.codes = pend_codes;
      sb.push_back(e);
      last_start = e.start;
    end
    @(posedge clk);
    @(negedge clk);
    pos++;
    if (m_pending && fd) m_pending = 1'b0;
    else if (acc) m_pending = 1'b1;
    if (acc) begin
      load_valid = 1'b0;
      taken      = 1'b1;
    end
    check_cycle();
  endtask

  task automatic offer(input logic [15:0] v, input logic [3:0] en, input logic b, input codes_t c);
    value      = v;
    digit_en   = en;
    blank_lz   = b;
    pend_codes = c;
    load_valid = 1'b1;
    taken      = 1'b0;
    for (int k = 0; k < 4 * FRAME && !taken; k++) tick();
    if (!taken) begin
      n_vec++;
      n_err++;
      $display("FAIL offer_timeout pos=%0d got not-accepted expected accepted", pos);
      load_valid = 1'b0;
    end
  endtask

  // Input scribbling without a handshake must never reach the display
  task automatic run_until(input int target);
    for (int k = 0; k < 8 * FRAME && pos < target; k++) begin
      if (!load_valid) begin
        value    = 16'($urandom);
        digit_en = 4'($urandom);
        blank_lz = 1'($urandom);
      end
      tick();
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog pos=%0d got timeout expected finish", pos);
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{16'h1A3F, 4'hF,    1'b0, {5'h11, 5'h1A, 5'h13, 5'h1F}};
    vecs[1] = '{16'h0005, 4'hF,    1'b1, {5'h00, 5'h00, 5'h00, 5'h15}};
    vecs[2] = '{16'h0000, 4'hF,    1'b1, {5'h00, 5'h00, 5'h00, 5'h10}};
    vecs[3] = '{16'h0A05, 4'hF,    1'b1, {5'h00, 5'h1A, 5'h10, 5'h15}};
    vecs[4] = '{16'h1234, 4'b0101, 1'b0, {5'h01, 5'h12, 5'h03, 5'h14}};
    vecs[5] = '{16'h00F0, 4'hF,    1'b1, {5'h00, 5'h00, 5'h1F, 5'h10}};

    n_vec = 0; n_err = 0; pos = 0; last_start = 0;
    m_pending = 1'b0; taken = 1'b0; cur_codes = '0; pend_codes = '0;
    rst = 1'b1; load_valid = 1'b1; value = 16'hFFFF; digit_en = 4'hF; blank_lz = 1'b0;

    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("rst_anodes", 32'(anodes), 32'(4'hF));
      check("rst_hex", 32'(hex), 32'(5'h00));
      check("rst_frame_done", 32'(frame_done), 32'(1'b0));
      check("rst_load_ready", 32'(load_ready), 32'(1'b1));
      check("rst_digit_idx", 32'(digit_idx), 32'(2'd0));
    end
    load_valid = 1'b0;
    rst = 1'b0;
    #1;
    check_cycle();

    run_until(2 * FRAME);

    for (int v = 0; v < 6; v++) begin
      offer(vecs[v].val, vecs[v].en, vecs[v].blz, vecs[v].codes);
      run_until(last_start + FRAME);
    end

    offer(16'h1111, 4'hF, 1'b0, {4{5'h11}});
    offer(16'h2222, 4'hF, 1'b0, {4{5'h12}});
    run_until(last_start + FRAME);

    run_until((pos / FRAME) * FRAME + FRAME - 1);
    check("fd_at_load", 32'(frame_done), 32'(1'b1));
    offer(16'h4444, 4'hF, 1'b0, {4{5'h14}});
    run_until(last_start + FRAME);

    offer(16'h5555, 4'hF, 1'b0, {4{5'h15}});
    run_until((pos / FRAME) * FRAME + 2 * RD + 4);
    check("pending_before_rst", 32'(load_ready), 32'(1'b0));
    rst = 1'b1;
    #1;
    check("midrst_anodes", 32'(anodes), 32'(4'hF));
    check("midrst_hex", 32'(hex), 32'(5'h00));
    check("midrst_frame_done", 32'(frame_done), 32'(1'b0));
    check("midrst_load_ready", 32'(load_ready), 32'(1'b1));
    check("midrst_digit_idx", 32'(digit_idx), 32'(2'd0));
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    pos = 0;
    m_pending = 1'b0;
    sb.delete();
    cur_codes = '0;
    #1;
    check_cycle();
    run_until(2 * FRAME);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/seg7_scanner.md
SEG7_SCANNER -- requirements
Module: seg7_scanner

Interface
REQ-001 The module SHALL have parameter NUM_DIGITS, default 8, giving the number of multiplexed digits (2..8).
REQ-002 The module SHALL have parameter REFRESH_DIV, default 100000, giving clock cycles per digit slot (>= BLANK_CYCLES+2).
REQ-003 The module SHALL have parameter BLANK_CYCLES, default 1000, giving the anti-ghosting dead time at the start of each slot (>= 1).
REQ-004 The clock port SHALL be clk, input, 1 bit; the block has one clock domain.
REQ-005 The reset port SHALL be rst, input, 1 bit; reset is asynchronous and active-high.
REQ-006 value SHALL be an input of 4*NUM_DIGITS bits: nibble i drives digit i, with digit 0 the rightmost.
REQ-007 digit_en SHALL be an input of NUM_DIGITS bits: per-digit enable.
REQ-008 blank_lz SHALL be a 1-bit input: leading-zero blanking enable.
REQ-009 load_valid SHALL be a 1-bit input: a new value/digit_en/blank_lz set is offered.
REQ-010 load_ready SHALL be a 1-bit output: the shadow register can accept a load.
REQ-011 hex SHALL be a 5-bit output {en, nibble[3:0]}, the segment-encoder input code; en=0 means the digit is dark.
REQ-012 anodes SHALL be an output of NUM_DIGITS bits, active-low digit strobes.
REQ-013 digit_idx SHALL be a $clog2(NUM_DIGITS)-bit output giving the current slot index.
REQ-014 frame_done SHALL be a 1-bit output: a one-cycle pulse at the last cycle of slot NUM_DIGITS-1.

Function
REQ-015 A slot counter SHALL count 0..REFRESH_DIV-1 and then wrap; at each wrap, digit_idx SHALL increment, wrapping from NUM_DIGITS-1 to 0.
REQ-016 The FSM SHALL have two states, BLANK and SHOW: BLANK covers counter values 0..BLANK_CYCLES-1, and SHOW covers the rest of the slot.
REQ-017 In BLANK, anodes SHALL be all ones and hex SHALL be 5'b0_0000.
REQ-018 In SHOW, anodes SHALL be ~(1<<digit_idx) and hex SHALL be {act_en[idx] & ~lz[idx], act_val nibble idx}.
REQ-019 All outputs SHALL be registered, with no combinational path from inputs to outputs.
REQ-020 When act_blank_lz=1, lz[i] SHALL be 1 for i>0 iff act_val nibbles i..NUM_DIGITS-1 are all zero.
REQ-021 lz[0] SHALL always be 0, so a value of 0 displays a single "0".
REQ-022 load_ready SHALL equal ~pending.
REQ-023 A load SHALL complete on the cycle where load_valid & load_ready are both high: shadow captures value, digit_en and blank_lz, and pending is set.
REQ-024 On the frame_done cycle with pending=1, the active registers SHALL take the shadow values and pending SHALL clear; load_ready returns high on the next cycle.
REQ-025 This makes updates tear-free: a new value first appears in slot 0 of the next frame.
REQ-026 A load accepted on the frame_done cycle itself (pending was 0) SHALL be applied at the following frame_done, not the current one.
REQ-027 While pending=1, load_valid SHALL be ignored, and the shadow SHALL hold its first-accepted contents.
REQ-028 Input changes that occur without a handshake SHALL NOT affect the display.

Reset
REQ-029 While rst=1, the module SHALL force: counter=0, digit_idx=0, state=BLANK, anodes all ones, hex=0, frame_done=0, pending=0, and active/shadow registers all zero.
REQ-030 load_valid SHALL be ignored while rst=1.
REQ-031 After rst deasserts, all digits SHALL be dark (act_en=0) until the first load is applied.
REQ-032 Reset asserted mid-slot or mid-pending SHALL discard any pending load; the first cycle after release is BLANK with digit_idx=0.

Structure
REQ-033 Package seg7_pkg SHALL hold the hex_code_t packed struct {logic en; logic [3:0] nibble;}, the constant HEX_BLANK = 5'b0_0000, and the state enum {BLANK, SHOW}.
REQ-034 Sub-module seg7_lz_mask SHALL compute the combinational NUM_DIGITS-bit lz vector from act_val and act_blank_lz; nothing else is split out.

Verification (REFRESH_DIV=8, BLANK_CYCLES=2, NUM_DIGITS=4)
REQ-035 Reset check: hold rst for 3 cycles, then release -> anodes=4'b1111 and hex=0 during reset; after release, anodes cycle 1110/1101/1011/0111 in SHOW with hex[4]=0 throughout; frame_done fires every 32 cycles.
REQ-036 Basic load: load 0x1A3F with en=4'hF and blank_lz=0 -> from the next frame, slots 0..3 show hex 1_1111, 1_0011, 1_1010, 1_0001; load_ready is low until frame_done, then high.
REQ-037 Leading-zero blanking: load 0x0005 with en=F and blank_lz=1 -> slot0 shows 1_0101 and slots 1..3 show 0_0000; loading 0x0000 shows only slot0 as 1_0000.
REQ-038 Double load: load A=0x1111, then offer B=0x2222 while pending -> B is not accepted; A is displayed; B is accepted after frame_done and displayed one frame later.
REQ-039 Load on the frame_done cycle: load 0x4444 exactly when frame_done=1 -> the next frame still shows the old value, and the frame after shows 0x4444.
REQ-040 Mid-operation reset: assert rst at slot 2 SHOW with a load pending -> outputs go to reset values immediately (asynchronous); after release the display is dark and load_ready=1.
